mips_mc_exec_units: RTL and testbench

- Control, storage and arithmetic unit for the multicycle MIPS core.
- Contains three parts:
  - a Moore control FSM that decodes opcode/funct into datapath selects and enables;
  - a 32-entry register file with two read ports and one write port;
  - a combinational ALU with zero flag.
- The core supplies the instruction fields, operand muxes, memory and PC. This block produces the control signals, register read data and the ALU result.

---
 rtl/mips_mc_exec_units.sv | 226 ++++++++++++++++++++++
 tb/tb_mips_mc_exec_units.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_exec_units.sv
// Control FSM, register file and ALU for the multicycle MIPS core.
// The core owns the instruction register, operand muxes, memory and PC;
// this block supplies control strobes/selects, register read data and the
// ALU result with its zero flag.
module mips_mc_exec_units #(
  parameter int unsigned DATA_WIDTH_P      = 32,
  parameter int unsigned ADDR_WIDTH_P      = 5,
  parameter int unsigned ALU_CNTRL_WIDTH_P = 3,
  parameter int unsigned FUNCT_WIDTH_P     = 6,
  parameter int unsigned OP_WIDTH_P        = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  // Control FSM
  input  logic [OP_WIDTH_P-1:0]        i_opcode,
  input  logic [FUNCT_WIDTH_P-1:0]     i_function,
  output logic                         o_enable_pc,
  output logic                         o_branch,
  output logic [1:0]                   o_pc_next_sel,
  output logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl,
  output logic                         o_alu_src_a_sel,
  output logic [1:0]                   o_alu_src_b_sel,
  output logic                         o_reg_wr_en,
  output logic                         o_instr_data_addr_sel,
  output logic                         o_instr_data_wr_en,
  output logic                         o_instr_wr_en,
  output logic                         o_reg_wr_addr_sel,
  output logic                         o_reg_wr_data_sel,
  // Register file
  input  logic [ADDR_WIDTH_P-1:0]      i_rd_addr_a,
  input  logic [ADDR_WIDTH_P-1:0]      i_rd_addr_b,
  input  logic [ADDR_WIDTH_P-1:0]      i_wr_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_wr_data,
  input  logic                         i_wr_enable,
  output logic [DATA_WIDTH_P-1:0]      o_rd_data_a,
  output logic [DATA_WIDTH_P-1:0]      o_rd_data_b,
  // ALU
  input  logic [ALU_CNTRL_WIDTH_P-1:0] i_alu_control,
  input  logic [DATA_WIDTH_P-1:0]      i_a,
  input  logic [DATA_WIDTH_P-1:0]      i_b,
  output logic [DATA_WIDTH_P-1:0]      o_result,
  output logic                         o_zero
);

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH_P;

  localparam logic [OP_WIDTH_P-1:0] OpLw    = OP_WIDTH_P'(6'b100011);
  localparam logic [OP_WIDTH_P-1:0] OpSw    = OP_WIDTH_P'(6'b101011);
  localparam logic [OP_WIDTH_P-1:0] OpRtype = OP_WIDTH_P'(6'b000000);
  localparam logic [OP_WIDTH_P-1:0] OpBeq   = OP_WIDTH_P'(6'b000100);
  localparam logic [OP_WIDTH_P-1:0] OpAddi  = OP_WIDTH_P'(6'b001000);
  localparam logic [OP_WIDTH_P-1:0] OpJ     = OP_WIDTH_P'(6'b000010);

  localparam logic [FUNCT_WIDTH_P-1:0] FnAdd = FUNCT_WIDTH_P'(6'b100000);
  localparam logic [FUNCT_WIDTH_P-1:0] FnSub = FUNCT_WIDTH_P'(6'b100010);
  localparam logic [FUNCT_WIDTH_P-1:0] FnAnd = FUNCT_WIDTH_P'(6'b100100);
  localparam logic [FUNCT_WIDTH_P-1:0] FnOr  = FUNCT_WIDTH_P'(6'b100101);
  localparam logic [FUNCT_WIDTH_P-1:0] FnXor = FUNCT_WIDTH_P'(6'b100110);
  localparam logic [FUNCT_WIDTH_P-1:0] FnSlt = FUNCT_WIDTH_P'(6'b101010);

  localparam logic [ALU_CNTRL_WIDTH_P-1:0] AluAnd  = ALU_CNTRL_WIDTH_P'(3'b000);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] AluOr   = ALU_CNTRL_WIDTH_P'(3'b001);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] AluAdd  = ALU_CNTRL_WIDTH_P'(3'b010);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] AluXor  = ALU_CNTRL_WIDTH_P'(3'b011);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] AluAndn = ALU_CNTRL_WIDTH_P'(3'b100);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] AluOrn  = ALU_CNTRL_WIDTH_P'(3'b101);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] AluSub  = ALU_CNTRL_WIDTH_P'(3'b110);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] AluSlt  = ALU_CNTRL_WIDTH_P'(3'b111);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StRtypeEx, StRtypeWb, StBeqEx, StAddiEx, StAddiWb, StJEx
  } state_e;

  state_e state_q, state_d;
  // Load vs store is latched in DECODE so the opcode is only looked at there.
  logic   is_lw_q, is_lw_d;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register and latched lw/sw flag; synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  // Next-state selection; opcode decoded only in DECODE.
  always_comb begin
    state_d = StFetch;
    is_lw_d = is_lw_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        is_lw_d = (i_opcode == OpLw);
        if ((i_opcode == OpLw) || (i_opcode == OpSw)) state_d = StMemAdr;
        else if (i_opcode == OpRtype)                 state_d = StRtypeEx;
        else if (i_opcode == OpBeq)                   state_d = StBeqEx;
        else if (i_opcode == OpAddi)                  state_d = StAddiEx;
        else if (i_opcode == OpJ)                     state_d = StJEx;
        else                                          state_d = StFetch;
      end
      StMemAdr:  state_d = is_lw_q ? StMemRd : StMemWr;
      StMemRd:   state_d = StMemWb;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
  end

  // Moore outputs per state; everything 0 by default except the ALU op (ADD).
  always_comb begin
    o_enable_pc           = 1'b0;
    o_branch              = 1'b0;
    o_pc_next_sel         = 2'b00;
    o_alu_cntrl           = AluAdd;
    o_alu_src_a_sel       = 1'b0;
    o_alu_src_b_sel       = 2'b00;
    o_reg_wr_en           = 1'b0;
    o_instr_data_addr_sel = 1'b0;
    o_instr_data_wr_en    = 1'b0;
    o_instr_wr_en         = 1'b0;
    o_reg_wr_addr_sel     = 1'b0;
    o_reg_wr_data_sel     = 1'b0;
    unique case (state_q)
      StFetch: begin
        o_alu_src_b_sel = 2'b01;
        o_instr_wr_en   = 1'b1;
        o_enable_pc     = 1'b1;
      end
      StDecode: o_alu_src_b_sel = 2'b11;
      StMemAdr: begin
        o_alu_src_a_sel = 1'b1;
        o_alu_src_b_sel = 2'b10;
      end
      StMemRd: o_instr_data_addr_sel = 1'b1;
      StMemWb: begin
        o_reg_wr_data_sel = 1'b1;
        o_reg_wr_en       = 1'b1;
      end
      StMemWr: begin
        o_instr_data_addr_sel = 1'b1;
        o_instr_data_wr_en    = 1'b1;
      end
      StRtypeEx: begin
        o_alu_src_a_sel = 1'b1;
        if (i_function == FnAdd)      o_alu_cntrl = AluAdd;
        else if (i_function == FnSub) o_alu_cntrl = AluSub;
        else if (i_function == FnAnd) o_alu_cntrl = AluAnd;
        else if (i_function == FnOr)  o_alu_cntrl = AluOr;
        else if (i_function == FnXor) o_alu_cntrl = AluXor;
        else if (i_function == FnSlt) o_alu_cntrl = AluSlt;
        else                          o_alu_cntrl = AluAdd;
      end
      StRtypeWb: begin
        o_reg_wr_addr_sel = 1'b1;
        o_reg_wr_en       = 1'b1;
      end
      StBeqEx: begin
        o_alu_src_a_sel = 1'b1;
        o_alu_cntrl     = AluSub;
        o_pc_next_sel   = 2'b01;
        o_branch        = 1'b1;
      end
      StAddiEx: begin
        o_alu_src_a_sel = 1'b1;
        o_alu_src_b_sel = 2'b10;
      end
      StAddiWb: o_reg_wr_en = 1'b1;
      StJEx: begin
        o_pc_next_sel = 2'b10;
        o_enable_pc   = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------

  logic [DATA_WIDTH_P-1:0] regs_q [NumRegs];

  // Synchronous clear has priority; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else if (i_wr_enable && (i_wr_addr != '0)) begin
      regs_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Asynchronous reads, no write bypass; r0 forced to zero.
  always_comb begin
    o_rd_data_a = (i_rd_addr_a == '0) ? '0 : regs_q[i_rd_addr_a];
    o_rd_data_b = (i_rd_addr_b == '0) ? '0 : regs_q[i_rd_addr_b];
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------

  // Combinational ALU; ADD/SUB wrap, SLT is a signed compare.
  always_comb begin
    o_result = '0;
    unique case (i_alu_control)
      AluAnd:  o_result = i_a & i_b;
      AluOr:   o_result = i_a | i_b;
      AluAdd:  o_result = i_a + i_b;
      AluXor:  o_result = i_a ^ i_b;
      AluAndn: o_result = i_a & ~i_b;
      AluOrn:  o_result = i_a | ~i_b;
      AluSub:  o_result = i_a - i_b;
      AluSlt:  o_result = {{(DATA_WIDTH_P-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
    o_zero = (o_result == '0);
  end

endmodule

// File: tb/tb_mips_mc_exec_units.sv
// Self-checking bench for mips_mc_exec_units: ALU vector table plus random ALU
// ops against arithmetic, register file against an array model, and control
// sequences against per-instruction state paths.
module tb_mips_mc_exec_units;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  i_opcode, i_function;
  logic        o_enable_pc, o_branch;
  logic [1:0]  o_pc_next_sel;
  logic [2:0]  o_alu_cntrl;
  logic        o_alu_src_a_sel;
  logic [1:0]  o_alu_src_b_sel;
  logic        o_reg_wr_en, o_instr_data_addr_sel, o_instr_data_wr_en, o_instr_wr_en;
  logic        o_reg_wr_addr_sel, o_reg_wr_data_sel;
  logic [4:0]  i_rd_addr_a, i_rd_addr_b, i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_wr_enable;
  logic [31:0] o_rd_data_a, o_rd_data_b;
  logic [2:0]  i_alu_control;
  logic [31:0] i_a, i_b, o_result;
  logic        o_zero;

  int n_cmp = 0;
  int n_err = 0;

  mips_mc_exec_units dut (
    .clk(clk), .reset(reset),
    .i_opcode(i_opcode), .i_function(i_function),
    .o_enable_pc(o_enable_pc), .o_branch(o_branch), .o_pc_next_sel(o_pc_next_sel),
    .o_alu_cntrl(o_alu_cntrl), .o_alu_src_a_sel(o_alu_src_a_sel),
    .o_alu_src_b_sel(o_alu_src_b_sel), .o_reg_wr_en(o_reg_wr_en),
    .o_instr_data_addr_sel(o_instr_data_addr_sel), .o_instr_data_wr_en(o_instr_data_wr_en),
    .o_instr_wr_en(o_instr_wr_en), .o_reg_wr_addr_sel(o_reg_wr_addr_sel),
    .o_reg_wr_data_sel(o_reg_wr_data_sel),
    .i_rd_addr_a(i_rd_addr_a), .i_rd_addr_b(i_rd_addr_b), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_wr_enable(i_wr_enable),
    .o_rd_data_a(o_rd_data_a), .o_rd_data_b(o_rd_data_b),
    .i_alu_control(i_alu_control), .i_a(i_a), .i_b(i_b),
    .o_result(o_result), .o_zero(o_zero)
  );

  always #5 clk = ~clk;

  typedef enum {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
                RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX} tb_st_e;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } alu_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Control word: {en_pc, branch, pc_sel, alu, src_a, src_b, rwe, asel, dwe, iwe, rwa, rwd}
  function automatic logic [15:0] pack(logic en_pc, logic br, logic [1:0] pcs, logic [2:0] alu,
                                       logic sa, logic [1:0] sb, logic rwe, logic asel,
                                       logic dwe, logic iwe, logic rwa, logic rwd);
    return {en_pc, br, pcs, alu, sa, sb, rwe, asel, dwe, iwe, rwa, rwd};
  endfunction

  function automatic logic [15:0] dut_ctl();
    return pack(o_enable_pc, o_branch, o_pc_next_sel, o_alu_cntrl, o_alu_src_a_sel,
                o_alu_src_b_sel, o_reg_wr_en, o_instr_data_addr_sel, o_instr_data_wr_en,
                o_instr_wr_en, o_reg_wr_addr_sel, o_reg_wr_data_sel);
  endfunction

  // Expected control word straight from the state output table.
  function automatic logic [15:0] exp_ctl(tb_st_e s, logic [5:0] fn);
    logic en_pc = 0, br = 0, sa = 0, rwe = 0, asel = 0, dwe = 0, iwe = 0, rwa = 0, rwd = 0;
    logic [1:0] pcs = 2'b00, sb = 2'b00;
    logic [2:0] alu = 3'b010;
    case (s)
      FETCH:   begin sb = 2'b01; iwe = 1; en_pc = 1; end
      DECODE:  sb = 2'b11;
      MEMADR:  begin sa = 1; sb = 2'b10; end
      MEMRD:   asel = 1;
      MEMWB:   begin rwd = 1; rwe = 1; end
      MEMWR:   begin asel = 1; dwe = 1; end
      RTYPEEX: begin
        sa = 1;
        case (fn)
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b100110: alu = 3'b011;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b010;
        endcase
      end
      RTYPEWB: begin rwa = 1; rwe = 1; end
      BEQEX:   begin sa = 1; alu = 3'b110; pcs = 2'b01; br = 1; end
      ADDIEX:  begin sa = 1; sb = 2'b10; end
      ADDIWB:  rwe = 1;
      JEX:     begin pcs = 2'b10; en_pc = 1; end
      default: ;
    endcase
    return pack(en_pc, br, pcs, alu, sa, sb, rwe, asel, dwe, iwe, rwa, rwd);
  endfunction

  // Run one instruction from FETCH, checking every cycle against its state path.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    tb_st_e path[$];
    path = '{FETCH, DECODE};
    case (op)
      6'b100011: path = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
      6'b101011: path = '{FETCH, DECODE, MEMADR, MEMWR};
      6'b000000: path = '{FETCH, DECODE, RTYPEEX, RTYPEWB};
      6'b000100: path = '{FETCH, DECODE, BEQEX};
      6'b001000: path = '{FETCH, DECODE, ADDIEX, ADDIWB};
      6'b000010: path = '{FETCH, DECODE, JEX};
      default: ;
    endcase
    i_opcode   = op;
    i_function = fn;
    foreach (path[k]) begin
      check($sformatf("ctl op=%b st=%s", op, path[k].name()), {16'h0, dut_ctl()},
            {16'h0, exp_ctl(path[k], fn)});
      step();
    end
  endtask

  function automatic logic [31:0] alu_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a ^ b;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return a - b;
      default: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  alu_vec_t   vecs[$];
  logic [31:0] model[32];
  logic [5:0]  known_ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0]  functs[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                            6'b101010, 6'b111111};

  initial begin
    reset = 1; i_opcode = 0; i_function = 0;
    i_rd_addr_a = 0; i_rd_addr_b = 0; i_wr_addr = 0; i_wr_data = 0; i_wr_enable = 0;
    i_alu_control = 0; i_a = 0; i_b = 0;
    step(); step();
    reset = 0;
    #1;

    // Reset state
    check("reset ctl is FETCH", {16'h0, dut_ctl()}, {16'h0, exp_ctl(FETCH, 6'h0)});
    i_rd_addr_a = 5'd17; i_rd_addr_b = 5'd31; #1;
    check("reset r17", o_rd_data_a, 32'h0);
    check("reset r31", o_rd_data_b, 32'h0);

    // ALU directed vectors
    vecs = '{
      '{3'b010, 32'd7, 32'd5, 32'd12, 1'b0},
      '{3'b110, 32'd7, 32'd5, 32'd2, 1'b0},
      '{3'b000, 32'd7, 32'd5, 32'd5, 1'b0},
      '{3'b001, 32'd7, 32'd5, 32'd7, 1'b0},
      '{3'b011, 32'd7, 32'd5, 32'd2, 1'b0},
      '{3'b010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1},
      '{3'b111, 32'h80000000, 32'd1, 32'd1, 1'b0},
      '{3'b111, 32'd1, 32'h80000000, 32'd0, 1'b1},
      '{3'b100, 32'h0000F0F0, 32'h0000FF00, 32'h000000F0, 1'b0},
      '{3'b101, 32'h0, 32'hFFFFFFFE, 32'h00000001, 1'b0},
      '{3'b110, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0},
      '{3'b110, 32'h1234, 32'h1234, 32'h0, 1'b1}
    };
    foreach (vecs[k]) begin
      i_alu_control = vecs[k].op; i_a = vecs[k].a; i_b = vecs[k].b; #1;
      check($sformatf("alu vec %0d result", k), o_result, vecs[k].res);
      check($sformatf("alu vec %0d zero", k), {31'h0, o_zero}, {31'h0, vecs[k].zero});
    end

    // ALU random
    for (int k = 0; k < 200; k++) begin
      i_alu_control = 3'($urandom_range(0, 7));
      i_a = $urandom(); i_b = ($urandom_range(0, 3) == 0) ? i_a : $urandom();
      #1;
      check($sformatf("alu rand op=%0d a=%h b=%h", i_alu_control, i_a, i_b), o_result,
            alu_model(i_alu_control, i_a, i_b));
      check("alu rand zero", {31'h0, o_zero},
            {31'h0, (alu_model(i_alu_control, i_a, i_b) == 32'h0)});
    end

    // Register file directed: write r3, old value during write cycle
    foreach (model[k]) model[k] = 32'h0;
    i_wr_enable = 1; i_wr_addr = 5'd3; i_wr_data = 32'hDEADBEEF; i_rd_addr_a = 5'd3; #1;
    check("r3 during write", o_rd_data_a, 32'h0);
    step();
    i_wr_enable = 0; #1;
    check("r3 after write", o_rd_data_a, 32'hDEADBEEF);
    i_wr_enable = 1; i_wr_addr = 5'd0; i_wr_data = 32'd5; i_rd_addr_a = 5'd0;
    step();
    i_wr_enable = 0; #1;
    check("r0 after write 5", o_rd_data_a, 32'h0);
    // Reset wins over a same-cycle write
    reset = 1; i_wr_enable = 1; i_wr_addr = 5'd5; i_wr_data = 32'h55AA55AA;
    step();
    reset = 0; i_wr_enable = 0; i_rd_addr_a = 5'd3; i_rd_addr_b = 5'd5; #1;
    check("r3 after reset", o_rd_data_a, 32'h0);
    check("r5 reset beats write", o_rd_data_b, 32'h0);

    // Register file random against array model
    for (int k = 0; k < 300; k++) begin
      i_wr_enable = 1'($urandom_range(0, 1));
      i_wr_addr   = 5'($urandom_range(0, 31));
      i_wr_data   = $urandom();
      i_rd_addr_a = ($urandom_range(0, 3) == 0) ? i_wr_addr : 5'($urandom_range(0, 31));
      i_rd_addr_b = 5'($urandom_range(0, 31));
      #1;
      check($sformatf("rf rand rd a r%0d", i_rd_addr_a), o_rd_data_a, model[i_rd_addr_a]);
      check($sformatf("rf rand rd b r%0d", i_rd_addr_b), o_rd_data_b, model[i_rd_addr_b]);
      @(posedge clk);
      if (i_wr_enable && i_wr_addr != 0) model[i_wr_addr] = i_wr_data;
      #1;
    end
    i_wr_enable = 0;

    // Control FSM: reset, then directed instructions (FSM now in FETCH)
    reset = 1; step(); reset = 0;
    run_instr(6'b100011, 6'h00);    // lw
    run_instr(6'b000000, 6'b101010); // slt
    run_instr(6'b000100, 6'h00);    // beq
    run_instr(6'b000010, 6'h00);    // j
    run_instr(6'b111111, 6'h00);    // unknown
    run_instr(6'b101011, 6'h00);    // sw
    run_instr(6'b001000, 6'h00);    // addi

    // Reset asserted while in MEMRD
    i_opcode = 6'b100011;
    step(); step(); step();
    check("mid-lw in MEMRD", {16'h0, dut_ctl()}, {16'h0, exp_ctl(MEMRD, 6'h0)});
    reset = 1; step(); reset = 0;
    check("reset from MEMRD -> FETCH", {16'h0, dut_ctl()}, {16'h0, exp_ctl(FETCH, 6'h0)});
    run_instr(6'b100011, 6'h00);

    // Random instruction stream
    for (int k = 0; k < 150; k++) begin
      logic [5:0] op;
      logic [5:0] fn;
      if ($urandom_range(0, 6) == 0) begin
        op = 6'($urandom_range(0, 63));
      end else begin
        op = known_ops[$urandom_range(0, 5)];
      end
      fn = ($urandom_range(0, 1) == 0) ? functs[$urandom_range(0, 6)]
                                       : 6'($urandom_range(0, 63));
      run_instr(op, fn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
